// File: rtl/slave_port.sv
// -----------------------------------------------------------------------------
// slave_port
//   Bus-side responder for the serial master protocol. It deserialises a
//   14-cycle header: the 14-bit address, with 8 data bits in the last 8 cycles
//   and a 3-bit burst code in the last 3 cycles. It then services single or
//   burst reads and writes against a local byte RAM, and serialises read data
//   back MSB first.
//
//   Parameters
//     MEM_AW   : local RAM address width (2^MEM_AW bytes)
//     SLAVE_ID : device select compared with header addr[13:12]
//
//   Ports
//     clock        in   system clock, all state on posedge
//     reset_n      in   asynchronous active-low reset
//     valid_s      in   master frame / write-beat strobe
//     write_en     in   1 = write frame, 0 = read frame (frame-start edge only)
//     addr_tx      in   serial header address, MSB first
//     data_tx      in   serial write data, MSB first
//     burst_mode   in   serial 3-bit burst code, MSB first
//     slave_ready  out  able to accept a new frame / next write beat
//     slave_valid  out  one-cycle pulse: a read byte follows on data_rx
//     data_rx      out  serial read data, MSB first
//     busy         out  high whenever the FSM is not idle
//
//   Build option
//     SLAVE_ADDR_MATCH_EN : when defined, a frame whose addr[13:12] differs
//     from SLAVE_ID is dropped silently after the header. The default build
//     accepts every frame and ignores addr[13:MEM_AW].
// -----------------------------------------------------------------------------
module slave_port #(
  parameter int         MEM_AW   = 12,
  parameter logic [1:0] SLAVE_ID = 2'd0
) (
  input  logic clock,
  input  logic reset_n,
  input  logic valid_s,
  input  logic write_en,
  input  logic addr_tx,
  input  logic data_tx,
  input  logic burst_mode,
  output logic slave_ready,
  output logic slave_valid,
  output logic data_rx,
  output logic busy
);

  typedef enum logic [3:0] {
    IDLE, HDR, WR_COMMIT, BW_WAIT, BW_DATA,
    RD_FETCH, RD_VALID, RD_SHIFT, RD_NEXT
  } state_t;

  state_t      state;
  logic        is_write;
  logic [3:0]  bit_cnt;    // header cycle 0..13, or data bit 0..7
  logic [13:0] addr;
  logic [7:0]  data;
  logic [2:0]  code;
  logic [9:0]  beat_cnt;
  logic [9:0]  beat_last;  // index of the final beat in this burst
  logic [7:0]  rd_shift;
  logic [7:0]  rd_data;
  logic [13:0] addr_nxt;
  logic        frame_ok;

  logic [7:0] mem [0:(1 << MEM_AW) - 1];

  // Address as it will look after this cycle's header shift. The device
  // select has to be judged on the final header edge, before addr updates.
  assign addr_nxt = {addr[12:0], addr_tx};

`ifdef SLAVE_ADDR_MATCH_EN
  assign frame_ok = (addr_nxt[13:12] == SLAVE_ID);
`else
  assign frame_ok = 1'b1;
`endif

  // addr[13] is shifted out of the header and never needed afterwards.
  logic unused_bits;
  assign unused_bits = ^{addr[13], SLAVE_ID};

  // Code 0 is a single beat; code n is 2^(n+2) beats.
  // NOTE: every always_comb output gets a default first so no latch is inferred.
  always_comb begin
    beat_last = 10'd0;
    if (code != 3'd0)
      beat_last = (10'd1 << ({1'b0, code} + 4'd2)) - 10'd1;
  end

  // NOTE: the RAM has no reset. Its contents survive reset_n, and leaving it
  // unreset keeps it mappable onto a plain synchronous RAM macro.
  always_ff @(posedge clock) begin
    if (state == WR_COMMIT)
      mem[addr[MEM_AW-1:0]] <= data;
    if (state == RD_FETCH)
      rd_data <= mem[addr[MEM_AW-1:0]];
  end

  // NOTE: sequential state uses non-blocking assignments only, so every
  // register here samples the values from before this clock edge.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state       <= IDLE;
      is_write    <= 1'b0;
      bit_cnt     <= 4'd0;
      addr        <= 14'd0;
      data        <= 8'd0;
      code        <= 3'd0;
      beat_cnt    <= 10'd0;
      rd_shift    <= 8'd0;
      slave_ready <= 1'b0;
      slave_valid <= 1'b0;
      data_rx     <= 1'b0;
      busy        <= 1'b0;
    end else begin
      // Pulsed / serial outputs are zero unless a state drives them.
      slave_valid <= 1'b0;
      data_rx     <= 1'b0;

      unique case (state)
        IDLE: begin
          slave_ready <= 1'b1;
          if (valid_s) begin
            state       <= HDR;
            is_write    <= write_en;
            bit_cnt     <= 4'd0;
            beat_cnt    <= 10'd0;
            slave_ready <= 1'b0;
            busy        <= 1'b1;
          end
        end

        HDR: begin
          if (!valid_s) begin
            state       <= IDLE;
            slave_ready <= 1'b1;
            busy        <= 1'b0;
          end else begin
            addr    <= addr_nxt;
            if (bit_cnt >= 4'd6)  data <= {data[6:0], data_tx};
            if (bit_cnt >= 4'd11) code <= {code[1:0], burst_mode};
            bit_cnt <= bit_cnt + 4'd1;
            if (bit_cnt == 4'd13) begin
              if (!frame_ok) begin
                state       <= IDLE;
                slave_ready <= 1'b1;
                busy        <= 1'b0;
              end else if (is_write) begin
                state <= WR_COMMIT;
              end else begin
                state <= RD_FETCH;
              end
            end
          end
        end

        WR_COMMIT: begin
          beat_cnt <= beat_cnt + 10'd1;
          if (beat_cnt == beat_last) begin
            state       <= IDLE;
            slave_ready <= 1'b1;
            busy        <= 1'b0;
          end else begin
            // The burst wraps inside the RAM window and never carries upward.
            addr[MEM_AW-1:0] <= addr[MEM_AW-1:0] + MEM_AW'(1);
            state            <= BW_WAIT;
            slave_ready      <= 1'b1;
          end
        end

        BW_WAIT: begin
          if (valid_s) begin
            state       <= BW_DATA;
            bit_cnt     <= 4'd0;
            slave_ready <= 1'b0;
          end
        end

        BW_DATA: begin
          if (!valid_s) begin
            state       <= IDLE;
            slave_ready <= 1'b1;
            busy        <= 1'b0;
          end else begin
            data    <= {data[6:0], data_tx};
            bit_cnt <= bit_cnt + 4'd1;
            if (bit_cnt == 4'd7) state <= WR_COMMIT;
          end
        end

        RD_FETCH: begin
          state       <= RD_VALID;
          slave_valid <= 1'b1;
        end

        RD_VALID: begin
          // bit7 goes out straight away; the rest wait in the shift register.
          data_rx  <= rd_data[7];
          rd_shift <= {rd_data[6:0], 1'b0};
          bit_cnt  <= 4'd0;
          state    <= RD_SHIFT;
        end

        RD_SHIFT: begin
          if (bit_cnt == 4'd7) begin
            beat_cnt <= beat_cnt + 10'd1;
            state    <= RD_NEXT;
          end else begin
            data_rx  <= rd_shift[7];
            rd_shift <= {rd_shift[6:0], 1'b0};
            bit_cnt  <= bit_cnt + 4'd1;
          end
        end

        RD_NEXT: begin
          if (beat_cnt == beat_last + 10'd1) begin
            state       <= IDLE;
            slave_ready <= 1'b1;
            busy        <= 1'b0;
          end else begin
            addr[MEM_AW-1:0] <= addr[MEM_AW-1:0] + MEM_AW'(1);
            state            <= RD_FETCH;
          end
        end

        default: begin
          state       <= IDLE;
          slave_ready <= 1'b1;
          busy        <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_slave_port.sv
// -----------------------------------------------------------------------------
// tb_slave_port
//   Directed bench for slave_port. It covers reset, single and burst writes
//   and reads (including address wrap), header abort, reset in the middle of
//   a read, a frame strobe on the cycle the FSM returns to idle, and handling
//   of the upper address bits. Inputs change and outputs are sampled 1 time
//   unit after each rising clock edge.
// -----------------------------------------------------------------------------
module tb_slave_port;

  logic clock      = 1'b0;
  logic reset_n    = 1'b0;
  logic valid_s    = 1'b0;
  logic write_en   = 1'b0;
  logic addr_tx    = 1'b0;
  logic data_tx    = 1'b0;
  logic burst_mode = 1'b0;
  logic slave_ready, slave_valid, data_rx, busy;

  int n_pass  = 0;
  int n_total = 0;

  slave_port #(.MEM_AW(12), .SLAVE_ID(2'd1)) dut (
    .clock      (clock),
    .reset_n    (reset_n),
    .valid_s    (valid_s),
    .write_en   (write_en),
    .addr_tx    (addr_tx),
    .data_tx    (data_tx),
    .burst_mode (burst_mode),
    .slave_ready(slave_ready),
    .slave_valid(slave_valid),
    .data_rx    (data_rx),
    .busy       (busy)
  );

  always #5 clock = ~clock;

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  // Frame-start edge followed by 14 header edges. If drop_at is in 0..13,
  // valid_s is low on that header edge and the task returns right after it.
  // After a full header, valid_s is left high; the caller decides when to drop it.
  task automatic send_header(input logic w, input logic [13:0] a,
                             input logic [7:0] d, input logic [2:0] c,
                             input int drop_at);
    valid_s  = 1'b1;
    write_en = w;
    tick();
    write_en = 1'b0;
    for (int k = 0; k < 14; k++) begin
      addr_tx    = a[13-k];
      data_tx    = 1'b0;
      burst_mode = 1'b0;
      if (k >= 6)  data_tx    = d[13-k];
      if (k >= 11) burst_mode = c[13-k];
      if (k == drop_at) valid_s = 1'b0;
      tick();
      if (k == drop_at) return;
    end
    addr_tx    = 1'b0;
    data_tx    = 1'b0;
    burst_mode = 1'b0;
  endtask

  // Waits for slave_ready (bounded), then sends one 8-bit write beat.
  // waited is -1 if slave_ready never rose.
  task automatic write_beat(input logic [7:0] d, output int waited);
    waited = 0;
    while (!slave_ready && waited < 20) begin
      tick();
      waited++;
    end
    if (!slave_ready) begin
      waited = -1;
      return;
    end
    valid_s = 1'b1;
    tick();
    for (int i = 0; i < 8; i++) begin
      data_tx = d[7-i];
      tick();
    end
    valid_s = 1'b0;
    data_tx = 1'b0;
  endtask

  // Waits for the slave_valid pulse (bounded) and collects the next 8
  // data_rx bits. waited counts edges up to the pulse, or is -1 on timeout.
  // sv_after is slave_valid as seen in the first data-bit cycle.
  task automatic get_byte(output logic [7:0] b, output int waited,
                          output logic sv_after);
    b        = 8'h00;
    waited   = 0;
    sv_after = 1'b0;
    do begin
      tick();
      waited++;
    end while (!slave_valid && waited < 20);
    if (!slave_valid) begin
      waited = -1;
      return;
    end
    for (int i = 0; i < 8; i++) begin
      tick();
      if (i == 0) sv_after = slave_valid;
      b = {b[6:0], data_rx};
    end
  endtask

  // Bounded wait for busy to fall; n = edges waited, or -1 on timeout.
  task automatic wait_idle(output int n);
    n = 0;
    while (busy && n < 40) begin
      tick();
      n++;
    end
    if (busy) n = -1;
  endtask

  task automatic test_reset();
    #12;
    n_total++; if (slave_ready !== 1'b0) $display("FAIL reset_ready: got %b want 0", slave_ready); else n_pass++;
    n_total++; if (slave_valid !== 1'b0) $display("FAIL reset_valid: got %b want 0", slave_valid); else n_pass++;
    n_total++; if (data_rx !== 1'b0)     $display("FAIL reset_data_rx: got %b want 0", data_rx); else n_pass++;
    n_total++; if (busy !== 1'b0)        $display("FAIL reset_busy: got %b want 0", busy); else n_pass++;
    #10 reset_n = 1'b1;
    n_total++; if (slave_ready !== 1'b0) $display("FAIL ready_before_edge: got %b want 0", slave_ready); else n_pass++;
    tick();
    n_total++; if (slave_ready !== 1'b1) $display("FAIL ready_after_release: got %b want 1", slave_ready); else n_pass++;
  endtask

  task automatic test_single();
    logic [7:0] b;
    int         w;
    int         n;
    logic       sv2;
    send_header(1'b1, 14'h0123, 8'hA5, 3'd0, -1);
    valid_s = 1'b0;
    n_total++; if (busy !== 1'b1)        $display("FAIL single_wr_busy: got %b want 1", busy); else n_pass++;
    n_total++; if (slave_ready !== 1'b0) $display("FAIL single_wr_ready: got %b want 0", slave_ready); else n_pass++;
    tick();
    n_total++; if (busy !== 1'b0)        $display("FAIL single_wr_done_busy: got %b want 0", busy); else n_pass++;
    n_total++; if (slave_ready !== 1'b1) $display("FAIL single_wr_done_ready: got %b want 1", slave_ready); else n_pass++;

    send_header(1'b0, 14'h0123, 8'h00, 3'd0, -1);
    valid_s = 1'b0;
    get_byte(b, w, sv2);
    n_total++; if (w !== 1)      $display("FAIL single_rd_latency: got %0d want 1", w); else n_pass++;
    n_total++; if (sv2 !== 1'b0) $display("FAIL single_rd_pulse_len: got %b want 0", sv2); else n_pass++;
    n_total++; if (b !== 8'hA5)  $display("FAIL single_rd_data: got %h want a5", b); else n_pass++;
    wait_idle(n);
    n_total++; if (n !== 2)      $display("FAIL single_rd_to_idle: got %0d want 2", n); else n_pass++;
  endtask

  task automatic test_burst_write();
    int w;
    send_header(1'b1, 14'h0FFE, 8'h10, 3'd1, -1);
    valid_s = 1'b0;
    for (int i = 1; i < 8; i++) begin
      write_beat(8'h10 + 8'(i), w);
      n_total++; if (w !== 1) $display("FAIL burst_wr_ready_beat%0d: got %0d want 1", i, w); else n_pass++;
    end
    tick();
    n_total++; if (busy !== 1'b0)        $display("FAIL burst_wr_done_busy: got %b want 0", busy); else n_pass++;
    n_total++; if (slave_ready !== 1'b1) $display("FAIL burst_wr_done_ready: got %b want 1", slave_ready); else n_pass++;
  endtask

  task automatic test_burst_read();
    logic [7:0] b;
    int         w;
    int         n;
    logic       sv2;
    send_header(1'b0, 14'h0FFE, 8'h00, 3'd1, -1);
    valid_s = 1'b0;
    for (int i = 0; i < 8; i++) begin
      get_byte(b, w, sv2);
      n_total++; if (w !== ((i == 0) ? 1 : 3)) $display("FAIL burst_rd_gap%0d: got %0d want %0d", i, w, (i == 0) ? 1 : 3); else n_pass++;
      n_total++; if (b !== 8'h10 + 8'(i))      $display("FAIL burst_rd_data%0d: got %h want %h", i, b, 8'h10 + 8'(i)); else n_pass++;
    end
    wait_idle(n);
    n_total++; if (n !== 2) $display("FAIL burst_rd_to_idle: got %0d want 2", n); else n_pass++;
  endtask

  task automatic test_abort();
    logic [7:0] b;
    int         w;
    int         n;
    logic       sv2;
    send_header(1'b1, 14'h0040, 8'h5A, 3'd0, -1);
    valid_s = 1'b0;
    tick();
    send_header(1'b1, 14'h0040, 8'hFF, 3'd0, 9);
    n_total++; if (busy !== 1'b0) $display("FAIL abort_busy: got %b want 0", busy); else n_pass++;
    tick();
    send_header(1'b0, 14'h0040, 8'h00, 3'd0, -1);
    valid_s = 1'b0;
    get_byte(b, w, sv2);
    n_total++; if (b !== 8'h5A) $display("FAIL abort_ram_kept: got %h want 5a", b); else n_pass++;
    wait_idle(n);
  endtask

  task automatic test_reset_mid_read();
    logic [7:0] b;
    int         w;
    int         n;
    logic       sv2;
    send_header(1'b0, 14'h0040, 8'h00, 3'd0, -1);
    valid_s = 1'b0;
    n = 0;
    do begin
      tick();
      n++;
    end while (!slave_valid && n < 20);
    n_total++; if (slave_valid !== 1'b1) $display("FAIL rst_rd_pulse: got %b want 1", slave_valid); else n_pass++;
    repeat (5) tick();  // bits 7,6,5,4,3 of 8'h5A; bit 3 is 1
    n_total++; if (data_rx !== 1'b1) $display("FAIL rst_rd_bit3: got %b want 1", data_rx); else n_pass++;
    reset_n = 1'b0;
    #1;
    n_total++; if (data_rx !== 1'b0)     $display("FAIL rst_rd_data_rx: got %b want 0", data_rx); else n_pass++;
    n_total++; if (slave_valid !== 1'b0) $display("FAIL rst_rd_valid: got %b want 0", slave_valid); else n_pass++;
    n_total++; if (busy !== 1'b0)        $display("FAIL rst_rd_busy: got %b want 0", busy); else n_pass++;
    n_total++; if (slave_ready !== 1'b0) $display("FAIL rst_rd_ready_low: got %b want 0", slave_ready); else n_pass++;
    #2 reset_n = 1'b1;
    tick();
    n_total++; if (slave_ready !== 1'b1) $display("FAIL rst_rd_ready_back: got %b want 1", slave_ready); else n_pass++;
    send_header(1'b0, 14'h0123, 8'h00, 3'd0, -1);
    valid_s = 1'b0;
    get_byte(b, w, sv2);
    n_total++; if (b !== 8'hA5) $display("FAIL rst_ram_retained: got %h want a5", b); else n_pass++;
    wait_idle(n);
  endtask

  task automatic test_back_to_back();
    logic [7:0] b;
    int         w;
    int         n;
    logic       sv2;
    send_header(1'b1, 14'h0300, 8'h77, 3'd0, -1);
    tick();  // WR_COMMIT edge with valid_s still high must not start a frame
    n_total++; if (busy !== 1'b0) $display("FAIL b2b_ignored_busy: got %b want 0", busy); else n_pass++;
    valid_s = 1'b0;
    tick();
    n_total++; if (busy !== 1'b0)        $display("FAIL b2b_idle_busy: got %b want 0", busy); else n_pass++;
    n_total++; if (slave_ready !== 1'b1) $display("FAIL b2b_idle_ready: got %b want 1", slave_ready); else n_pass++;
    send_header(1'b0, 14'h0300, 8'h00, 3'd0, -1);
    valid_s = 1'b0;
    get_byte(b, w, sv2);
    n_total++; if (b !== 8'h77) $display("FAIL b2b_read: got %h want 77", b); else n_pass++;
    wait_idle(n);
  endtask

`ifdef SLAVE_ADDR_MATCH_EN
  task automatic test_addr_field();
    logic [7:0] b;
    int         w;
    int         n;
    logic       sv2;
    send_header(1'b1, 14'h1055, 8'h11, 3'd0, -1);
    valid_s = 1'b0;
    tick();
    send_header(1'b1, 14'h0055, 8'hEE, 3'd0, -1);
    valid_s = 1'b0;
    n_total++; if (busy !== 1'b0) $display("FAIL match_reject_busy: got %b want 0", busy); else n_pass++;
    send_header(1'b0, 14'h0055, 8'h00, 3'd0, -1);
    valid_s = 1'b0;
    get_byte(b, w, sv2);
    n_total++; if (w !== -1) $display("FAIL match_reject_read: got %0d want -1", w); else n_pass++;
    send_header(1'b1, 14'h1055, 8'h3C, 3'd0, -1);
    valid_s = 1'b0;
    tick();
    send_header(1'b0, 14'h1055, 8'h00, 3'd0, -1);
    valid_s = 1'b0;
    get_byte(b, w, sv2);
    n_total++; if (b !== 8'h3C) $display("FAIL match_accept_data: got %h want 3c", b); else n_pass++;
    wait_idle(n);
  endtask
`else
  task automatic test_addr_field();
    logic [7:0] b;
    int         w;
    int         n;
    logic       sv2;
    send_header(1'b1, 14'h3055, 8'h3C, 3'd0, -1);
    valid_s = 1'b0;
    tick();
    send_header(1'b0, 14'h0055, 8'h00, 3'd0, -1);
    valid_s = 1'b0;
    get_byte(b, w, sv2);
    n_total++; if (w !== 1)     $display("FAIL upper_addr_latency: got %0d want 1", w); else n_pass++;
    n_total++; if (b !== 8'h3C) $display("FAIL upper_addr_ignored: got %h want 3c", b); else n_pass++;
    wait_idle(n);
  endtask
`endif

  initial begin
    test_reset();
    test_single();
    test_burst_write();
    test_burst_read();
    test_abort();
    test_reset_mid_read();
    test_back_to_back();
    test_addr_field();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
